// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator datapath types and constants
package calc_pkg;

    // Default operand width, shared by the multiplier and the divider.
    localparam int CALC_WIDTH = 8;

    // Multiplier sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/mult_control.sv
// rtl/mult_control.sv - start/done sequencer for the shift-add multiplier
//
// Ports:
//   Clock, Reset_n : clock and asynchronous active-low reset
//   Start          : level request, honoured only in IDLE
//   last           : datapath counter is on its final step
//   load           : capture operands this cycle (IDLE and Start)
//   step           : perform one add/shift step this cycle
//   Busy, Done     : registered status flags, never high together
module mult_control
    import calc_pkg::*;
(
    input  logic Clock,
    input  logic Reset_n,
    input  logic Start,
    input  logic last,
    output logic load,
    output logic step,
    output logic Busy,
    output logic Done
);

    mult_state_t state;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state <= BUSY;
                        Busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (last) begin
                        state <= DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end
                end
                DONE: begin
                    // Start must drop before another run can be accepted.
                    if (!Start) begin
                        state <= IDLE;
                        Done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

    assign load = (state == IDLE) && Start;
    assign step = (state == BUSY);

endmodule

// File: rtl/unsigned_multiplier.sv
// rtl/unsigned_multiplier.sv - sequential shift-add unsigned multiplier, one bit per clock
//
// Ports:
//   Clock, Reset_n : clock and asynchronous active-low reset
//   Multiplicand   : operand M, sampled when a start is accepted
//   Multiplier     : operand Q, sampled when a start is accepted
//   Start          : level request, accepted only when idle
//   Product        : {A, Q}, final while Done=1 and held until the next start
//   Busy, Done     : status flags
module unsigned_multiplier
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
    input  logic               Start,
    output logic [2*WIDTH-1:0] Product,
    output logic               Busy,
    output logic               Done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum;
    logic             load;
    logic             step;
    logic             last;

    assign last = (cnt == CNT_LAST);

    mult_control u_control (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Start   (Start),
        .last    (last),
        .load    (load),
        .step    (step),
        .Busy    (Busy),
        .Done    (Done)
    );

    // One extra bit keeps the carry; it becomes A's MSB after the shift.
    assign sum = q_reg[0] ? ({1'b0, acc} + {1'b0, m_reg}) : {1'b0, acc};

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            acc   <= '0;
            q_reg <= '0;
            m_reg <= '0;
            cnt   <= '0;
        end else if (load) begin
            acc   <= '0;
            q_reg <= Multiplier;
            m_reg <= Multiplicand;
            cnt   <= '0;
        end else if (step) begin
            // {sum, Q} shifted right by one: the consumed multiplier bit drops out.
            {acc, q_reg} <= {sum, q_reg[WIDTH-1:1]};
            cnt          <= cnt + CW'(1);
        end
    end

    assign Product = {acc, q_reg};

endmodule

// File: tb/tb_unsigned_multiplier.sv
// tb/tb_unsigned_multiplier.sv - self-checking bench for unsigned_multiplier
module tb_unsigned_multiplier;

    localparam int W = 8;
    localparam int LAT = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [W-1:0]   mcand = '0;
    logic [W-1:0]   mplier = '0;
    logic           start = 1'b0;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    unsigned_multiplier #(.WIDTH(W)) dut (
        .Clock        (clk),
        .Reset_n      (rst_n),
        .Multiplicand (mcand),
        .Multiplier   (mplier),
        .Start        (start),
        .Product      (product),
        .Busy         (busy),
        .Done         (done)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a run lasts LAT cycles after acceptance, result is plain M*Q,
    // Done persists while Start is held, and the product is held until the next run.
    int          m_left = 0;
    bit          m_done = 1'b0;
    bit          m_pvalid = 1'b1;
    logic [15:0] m_prod = '0;
    logic [15:0] m_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left   = 0;
            m_done   = 1'b0;
            m_prod   = '0;
            m_pvalid = 1'b1;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done   = 1'b1;
                m_prod   = m_pend;
                m_pvalid = 1'b1;
            end
        end else if (m_done) begin
            if (!start) m_done = 1'b0;
        end else if (start) begin
            m_left   = LAT;
            m_pend   = 16'(mcand) * 16'(mplier);
            m_pvalid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_left > 0));
            check("done", 32'(done), 32'(m_done));
            check("busy_done_exclusive", 32'(busy & done), 32'd0);
            if (m_pvalid) check("product", 32'(product), 32'(m_prod));
        end
    end

    task automatic start_pulse(input logic [W-1:0] m, input logic [W-1:0] q);
        @(posedge clk); #2;
        mcand = m; mplier = q; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) check({name, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // 13 x 11: Busy exactly 8 sampled cycles, then Done.
        start_pulse(8'd13, 8'd11);
        begin
            int bcount = 0;
            for (int i = 0; i < 20 && !done; i++) begin
                @(negedge clk);
                if (busy) bcount++;
            end
            check("busy_cycles_13x11", 32'(bcount), 32'd8);
        end
        check("done_13x11", 32'(done), 32'd1);
        check("prod_13x11", 32'(product), 32'h008F);

        start_pulse(8'd255, 8'd255);
        wait_done("ff_ff");
        check("prod_255x255", 32'(product), 32'hFE01);

        start_pulse(8'd0, 8'd200);
        wait_done("zero");
        check("prod_0x200", 32'(product), 32'h0000);

        start_pulse(8'd1, 8'd200);
        wait_done("one");
        check("prod_1x200", 32'(product), 32'h00C8);

        // Start held across completion; operands changed mid-run.
        @(posedge clk); #2;
        mcand = 8'd20; mplier = 8'd12; start = 1'b1;
        @(posedge clk); #2;
        mcand = 8'd99; mplier = 8'd77;
        wait_done("hold");
        repeat (3) @(negedge clk);
        check("hold_done", 32'(done), 32'd1);
        check("hold_busy", 32'(busy), 32'd0);
        check("prod_20x12", 32'(product), 32'd240);
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        check("idle_done", 32'(done), 32'd0);
        check("idle_product_held", 32'(product), 32'd240);

        // Reset in the middle of a 100 x 3 run.
        start_pulse(8'd100, 8'd3);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_product", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_pulse(8'd7, 8'd9);
        wait_done("after_reset");
        check("prod_7x9", 32'(product), 32'd63);

        for (int n = 0; n < 1000; n++) begin
            start_pulse(W'($urandom), W'($urandom));
            wait_done("random");
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
